// File: rtl/dma_pack_nx_if.sv
// Streaming bus between the video capture path and the DMA packer.
// The master drives pixel words and frame restart; the slave returns packed write words.
interface dma_pack_nx_if #(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned RATIO  = 2,
    parameter int unsigned WCNT_W = 12
);
    localparam int unsigned OUT_W = IN_W * RATIO;

    logic              dma_rst_i;
    logic              dma_de_i;
    logic [IN_W-1:0]   dma_d_i;
    logic              dma_de_o;
    logic              dma_we_o;
    logic [OUT_W-1:0]  dma_d_o;
    logic [RATIO-1:0]  dma_lane_o;
    logic              dma_eol_o;
    logic [WCNT_W-1:0] dma_wcnt_o;

    modport master (
        output dma_rst_i, dma_de_i, dma_d_i,
        input  dma_de_o, dma_we_o, dma_d_o, dma_lane_o, dma_eol_o, dma_wcnt_o
    );

    modport slave (
        input  dma_rst_i, dma_de_i, dma_d_i,
        output dma_de_o, dma_we_o, dma_d_o, dma_lane_o, dma_eol_o, dma_wcnt_o
    );
endinterface

// File: rtl/dma_pack_nx.sv
// Packs RATIO consecutive IN_W-bit video words into one write word, LSB lane first,
// flushing a lane-masked partial word at end of line and counting writes per line.
module dma_pack_nx #(
    parameter int unsigned IN_W     = 16,
    parameter int unsigned RATIO    = 2,
    parameter int unsigned FLUSH_EN = 1,
    parameter int unsigned WCNT_W   = 12
) (
    input  logic          sys_clk,
    input  logic          rst,
    dma_pack_nx_if.slave  bus
);
    localparam int unsigned OUT_W  = IN_W * RATIO;
    localparam int unsigned LANE_W = $clog2(RATIO);
    localparam int unsigned SHD_W  = (RATIO - 1) * IN_W;

    generate
        if (RATIO != 2 && RATIO != 4 && RATIO != 8) begin : g_bad_ratio
            $error("dma_pack_nx: RATIO must be 2, 4 or 8");
        end
    endgenerate

    logic              de_q;
    logic [LANE_W-1:0] lane_cnt;
    logic [SHD_W-1:0]  shadow;
    logic              we_q;
    logic [OUT_W-1:0]  d_q;
    logic [RATIO-1:0]  lane_q;
    logic              eol_q;
    logic [WCNT_W-1:0] wcnt_q;

    logic              rise_c;
    logic              fall_c;
    logic [LANE_W-1:0] eff_lane_c;
    logic              last_c;
    logic [WCNT_W-1:0] wcnt_inc_c;
    logic [OUT_W-1:0]  flush_mask_c;
    logic [RATIO-1:0]  lane_mask_c;

    // Edge detect and lane selection; a rising edge always realigns to lane 0.
    always_comb begin
        rise_c     = bus.dma_de_i && !de_q;
        fall_c     = !bus.dma_de_i && de_q;
        eff_lane_c = rise_c ? '0 : lane_cnt;
        last_c     = (eff_lane_c == LANE_W'(RATIO - 1));
        wcnt_inc_c = (wcnt_q == '1) ? wcnt_q : wcnt_q + WCNT_W'(1);
    end

    // Partial-word masks: only lanes captured so far in this word are valid.
    always_comb begin
        flush_mask_c = '0;
        lane_mask_c  = '0;
        for (int i = 0; i < int'(RATIO); i++) begin
            if (i < int'(lane_cnt)) begin
                flush_mask_c[i*IN_W +: IN_W] = '1;
                lane_mask_c[i]               = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst || bus.dma_rst_i) begin
            de_q     <= 1'b0;
            lane_cnt <= '0;
            shadow   <= '0;
            we_q     <= 1'b0;
            d_q      <= '0;
            lane_q   <= '0;
            eol_q    <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            de_q   <= bus.dma_de_i;
            we_q   <= 1'b0;
            d_q    <= '0;
            lane_q <= '0;
            eol_q  <= 1'b0;
            if (bus.dma_de_i) begin
                if (rise_c) begin
                    wcnt_q <= '0;
                end
                if (last_c) begin
                    we_q     <= 1'b1;
                    d_q      <= {bus.dma_d_i, shadow};
                    lane_q   <= '1;
                    lane_cnt <= '0;
                    wcnt_q   <= wcnt_inc_c;
                end else begin
                    shadow[int'(eff_lane_c)*IN_W +: IN_W] <= bus.dma_d_i;
                    lane_cnt <= eff_lane_c + LANE_W'(1);
                end
            end else if (fall_c) begin
                eol_q    <= 1'b1;
                lane_cnt <= '0;
                if (FLUSH_EN != 0 && lane_cnt != '0) begin
                    we_q   <= 1'b1;
                    d_q    <= {IN_W'(0), shadow} & flush_mask_c;
                    lane_q <= lane_mask_c;
                    wcnt_q <= wcnt_inc_c;
                end
            end
        end
    end

    assign bus.dma_de_o   = de_q;
    assign bus.dma_we_o   = we_q;
    assign bus.dma_d_o    = d_q;
    assign bus.dma_lane_o = lane_q;
    assign bus.dma_eol_o  = eol_q;
    assign bus.dma_wcnt_o = wcnt_q;
endmodule
